// File: rtl/seq_div.sv
// Signed restoring divider: quotient truncates toward zero, remainder takes the dividend's sign.
// Ports: clk, rst (async active-low), start/dividend/divisor in; busy, done, q, r, dz out.
module seq_div #(
  parameter int Nb = 2,
  parameter int n  = 2**Nb
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] q,
  output logic [n-1:0] r,
  output logic         dz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [n-1:0]  a_q;
  logic [n-1:0]  b_q;
  logic [n:0]    p_q;
  logic          sa_q, sb_q;
  logic [Nb-1:0] cnt_q;
  logic          done_q;
  logic [n-1:0]  q_q, r_q;
  logic          dz_q;

  logic ld, step, fin;

  logic [n:0]   p_sh;
  logic [n+1:0] diff;
  logic         neg;
  logic [n-1:0] mag_a, mag_b;
  logic [n-1:0] q_fix, r_fix;

  // a_q holds the dividend magnitude and fills with quotient bits
  assign p_sh  = {p_q[n-1:0], a_q[n-1]};
  assign diff  = {1'b0, p_sh} - {2'b00, b_q};
  assign neg   = diff[n+1];

  // -2**(n-1) maps to unsigned 2**(n-1)
  assign mag_a = dividend[n-1] ? {n{1'b0}} - dividend : dividend;
  assign mag_b = divisor[n-1]  ? {n{1'b0}} - divisor  : divisor;

  assign q_fix = (sa_q ^ sb_q) ? {n{1'b0}} - a_q : a_q;
  assign r_fix = sa_q ? {n{1'b0}} - p_q[n-1:0] : p_q[n-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    ld   = (state_q == IDLE) && start;
    step = (state_q == CALC);
    fin  = (state_q == FIX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      q_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ld) begin
        a_q   <= mag_a;
        b_q   <= mag_b;
        p_q   <= '0;
        sa_q  <= dividend[n-1];
        sb_q  <= divisor[n-1];
        cnt_q <= Nb'(n-1);
      end
      if (step) begin
        a_q   <= {a_q[n-2:0], ~neg};
        p_q   <= neg ? p_sh : diff[n:0];
        cnt_q <= cnt_q - Nb'(1);
      end
      if (fin) begin
        done_q <= 1'b1;
        dz_q   <= (b_q == '0);
        // zero divisor: all-ones quotient, remainder is the dividend
        q_q    <= (b_q == '0) ? '1 : q_fix;
        r_q    <= r_fix;
      end
    end
  end

  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div at n=4.
// Covers signs, wrap, divide-by-zero, back-to-back starts and reset abort.
module tb_seq_div;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] q;
  logic [3:0] r;
  logic       dz;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] ta [18];
  logic [3:0] tb [18];
  logic [3:0] eq [18];
  logic [3:0] er [18];

  seq_div #(.Nb(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .dz       (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input logic [3:0] a,
                         input logic [3:0] b,
                         input logic [3:0] xq,
                         input logic [3:0] xr,
                         input logic       xdz,
                         input string      tag);
    int   edges;
    logic got;
    logic busy_ok;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    busy_ok  = busy;
    edges    = 0;
    got      = 1'b0;
    while (!got && edges < 12) begin
      @(posedge clk);
      #1;
      edges++;
      dividend = 4'($urandom);
      divisor  = 4'($urandom);
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    chk({tag, "_lat"}, edges, 5);
    chk({tag, "_busy"}, busy_ok, 1);
    chk({tag, "_q"}, q, xq);
    chk({tag, "_r"}, r, xr);
    chk({tag, "_dz"}, dz, xdz);
    chk({tag, "_idle"}, busy, 0);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int   ndone;
    logic seen;
    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_dz", dz, 0);
    @(negedge clk);
    rst = 1'b1;

    run_div(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, "p7_p2");
    run_div(4'h9, 4'd2, 4'hD, 4'hF, 1'b0, "m7_p2");
    run_div(4'd7, 4'hE, 4'hD, 4'd1, 1'b0, "p7_m2");
    run_div(4'h9, 4'hE, 4'd3, 4'hF, 1'b0, "m7_m2");
    run_div(4'h8, 4'hF, 4'h8, 4'd0, 1'b0, "m8_m1");
    run_div(4'h8, 4'd1, 4'h8, 4'd0, 1'b0, "m8_p1");
    run_div(4'd5, 4'd0, 4'hF, 4'd5, 1'b1, "p5_z");
    run_div(4'h8, 4'd0, 4'hF, 4'h8, 1'b1, "m8_z");
    run_div(4'd3, 4'd7, 4'd0, 4'd3, 1'b0, "p3_p7");
    run_div(4'hF, 4'd7, 4'd0, 4'hF, 1'b0, "m1_p7");
    run_div(4'd7, 4'd7, 4'd1, 4'd0, 1'b0, "p7_p7");

    // start held high, operands change every cycle
    for (int i = 0; i < 18; i++) begin
      ta[i] = 4'($urandom);
      tb[i] = 4'($urandom);
      eq[i] = '0;
      er[i] = '0;
    end
    ta[0]  = 4'd6;  tb[0]  = 4'hE; eq[0]  = 4'hD; er[0]  = 4'd0;
    ta[6]  = 4'hB;  tb[6]  = 4'd3; eq[6]  = 4'hF; er[6]  = 4'hE;
    ta[12] = 4'h9;  tb[12] = 4'hC; eq[12] = 4'd1; er[12] = 4'hD;
    ndone = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      start    = 1'b1;
      dividend = ta[c];
      divisor  = tb[c];
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (c >= 5) begin
          chk($sformatf("b2b_q%0d", c), q, eq[c-5]);
          chk($sformatf("b2b_r%0d", c), r, er[c-5]);
        end
      end
    end
    start = 1'b0;
    chk("b2b_count", ndone, 3);

    // reset two edges into a division aborts it
    @(negedge clk);
    dividend = 4'd7;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("abort_busy", busy, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("hold_q", q, 4'd1);
    chk("hold_r", r, 4'hD);
    rst = 1'b0;
    #1;
    chk("abort_busy0", busy, 0);
    chk("abort_done0", done, 0);
    chk("abort_q0", q, 0);
    chk("abort_r0", r, 0);
    chk("abort_dz0", dz, 0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("abort_nodone", seen, 0);
    run_div(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, "p6_p3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
